// File: rtl/jtframe_sdram_arb_if.sv
// Bus bundle between the slot bank, the arbiter and the SDRAM command sequencer.
//
// Slot side:  slot_req/slot_rnw/slot_addr/slot_wrdata come from the slots;
//             slot_we/din_ok/dout go back to them.
// SDRAM side: sdram_req/sdram_rnw/sdram_addr/sdram_wrdata go to the controller;
//             sdram_ack/sdram_rdy/sdram_din come back from it.
//
// modport master : the arbiter view (drives sdram_* commands and slot results)
// modport slave  : the environment view (slots + controller)
interface jtframe_sdram_arb_if #(
   parameter int SLOTS = 4
);
   logic [SLOTS-1:0]    slot_req;
   logic [SLOTS-1:0]    slot_rnw;
   logic [SLOTS*22-1:0] slot_addr;
   logic [SLOTS*32-1:0] slot_wrdata;
   logic [SLOTS-1:0]    slot_we;
   logic                din_ok;
   logic [31:0]         dout;

   logic                sdram_req;
   logic                sdram_rnw;
   logic [21:0]         sdram_addr;
   logic [31:0]         sdram_wrdata;
   logic                sdram_ack;
   logic                sdram_rdy;
   logic [31:0]         sdram_din;

   modport master (
      input  slot_req, slot_rnw, slot_addr, slot_wrdata,
      output slot_we, din_ok, dout,
      output sdram_req, sdram_rnw, sdram_addr, sdram_wrdata,
      input  sdram_ack, sdram_rdy, sdram_din
   );

   modport slave (
      output slot_req, slot_rnw, slot_addr, slot_wrdata,
      input  slot_we, din_ok, dout,
      input  sdram_req, sdram_rnw, sdram_addr, sdram_wrdata,
      output sdram_ack, sdram_rdy, sdram_din
   );
endinterface

// File: rtl/jtframe_sdram_arb.sv
// Shares one SDRAM controller port among SLOTS request slots. One transaction
// is in flight at a time: a pending slot is granted, its command is forwarded
// and held until the controller acknowledges, then the returned word is routed
// back with a one-hot slot_we and a one-cycle din_ok.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus          jtframe_sdram_arb_if.master: slot requests/results and the
//                controller command/response signals
//   timeout      sticky flag, set when a transaction is aborted after TOUT
//                cycles without sdram_rdy; cleared only by reset
//   st_dbg       current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Handshake: sdram_req is a level held with a stable command until the
// controller pulses sdram_ack for one cycle; sdram_rdy is a one-cycle pulse
// that completes the command (read data valid on sdram_din). ack/rdy are only
// looked at in REQ/WAIT. Slot requests are levels sampled only in IDLE.
module jtframe_sdram_arb #(
   parameter int SLOTS = 4,
   parameter int FIXED = 0,
   parameter int TOUT  = 255
)(
   input  logic                 clk,
   input  logic                 rst_n,
   jtframe_sdram_arb_if.master  bus,
   output logic                 timeout,
   output logic [1:0]           st_dbg
);

   localparam int LW = $clog2(SLOTS);
   localparam int CW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
   localparam logic [CW-1:0] TOUT_C = CW'(TOUT);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   state_t          state, state_nxt;
   logic [LW-1:0]   last, last_nxt, win;
   logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
   logic [SLOTS-1:0] we_nxt;
   logic            din_ok_nxt, req_nxt, rnw_nxt, tout_nxt;
   logic [31:0]     dout_nxt, wrdata_nxt;
   logic [21:0]     addr_nxt;

   assign st_dbg  = state;
   assign cnt_inc = cnt + 1'b1;

   // Winner selection. Round-robin scans upward starting just after the last
   // granted slot, wrapping around; fixed priority always scans from slot 0.
   function automatic logic [LW-1:0] pick(input logic [SLOTS-1:0] req,
                                          input logic [LW-1:0]    prev);
      logic    found;
      int      idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         idx = (FIXED != 0) ? i : (int'(prev) + 1 + i) % SLOTS;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = LW'(idx);
         end
      end
   endfunction

   assign win = pick(bus.slot_req, last);

   always_comb begin
      state_nxt  = state;
      req_nxt    = bus.sdram_req;
      rnw_nxt    = bus.sdram_rnw;
      addr_nxt   = bus.sdram_addr;
      wrdata_nxt = bus.sdram_wrdata;
      we_nxt     = bus.slot_we;
      din_ok_nxt = 1'b0;
      dout_nxt   = bus.dout;
      tout_nxt   = timeout;
      last_nxt   = last;
      cnt_nxt    = cnt;
      case (state)
         IDLE: begin
            we_nxt = '0;
            if (|bus.slot_req) begin
               state_nxt  = REQ;
               req_nxt    = 1'b1;
               we_nxt     = {{(SLOTS-1){1'b0}}, 1'b1} << win;
               rnw_nxt    = bus.slot_rnw[win];
               addr_nxt   = bus.slot_addr[22*win +: 22];
               wrdata_nxt = bus.slot_wrdata[32*win +: 32];
               last_nxt   = win;
               cnt_nxt    = '0;
            end
         end
         REQ: begin
            if (bus.sdram_ack) begin
               req_nxt = 1'b0;
               // A controller that completes in the ack cycle skips WAIT.
               if (bus.sdram_rdy) begin
                  state_nxt  = DONE;
                  din_ok_nxt = 1'b1;
                  if (bus.sdram_rnw) dout_nxt = bus.sdram_din;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.sdram_rdy) begin
               state_nxt  = DONE;
               din_ok_nxt = 1'b1;
               if (bus.sdram_rnw) dout_nxt = bus.sdram_din;
            end else if (TOUT != 0 && cnt_inc == TOUT_C) begin
               // Give up on a controller that never answers; the slot sees no din_ok.
               state_nxt = IDLE;
               tout_nxt  = 1'b1;
               we_nxt    = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            we_nxt    = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         bus.slot_we      <= '0;
         bus.din_ok       <= 1'b0;
         bus.dout         <= '0;
         bus.sdram_req    <= 1'b0;
         bus.sdram_rnw    <= 1'b1;
         bus.sdram_addr   <= '0;
         bus.sdram_wrdata <= '0;
         timeout          <= 1'b0;
         last             <= LW'(SLOTS-1);
         cnt              <= '0;
      end else begin
         state            <= state_nxt;
         bus.slot_we      <= we_nxt;
         bus.din_ok       <= din_ok_nxt;
         bus.dout         <= dout_nxt;
         bus.sdram_req    <= req_nxt;
         bus.sdram_rnw    <= rnw_nxt;
         bus.sdram_addr   <= addr_nxt;
         bus.sdram_wrdata <= wrdata_nxt;
         timeout          <= tout_nxt;
         last             <= last_nxt;
         cnt              <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Bench for jtframe_sdram_arb: a round-robin instance (u_m, TOUT=8) checked
// through grant/response scoreboards, plus a fixed-priority instance (u_f).
module tb_jtframe_sdram_arb;
   localparam int SLOTS = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tout_m, tout_f;
   logic [1:0] st_m, st_f;

   always #5 clk = ~clk;

   jtframe_sdram_arb_if #(.SLOTS(SLOTS)) if_m ();
   jtframe_sdram_arb_if #(.SLOTS(SLOTS)) if_f ();

   jtframe_sdram_arb #(.SLOTS(SLOTS), .FIXED(0), .TOUT(8)) u_m (
      .clk(clk), .rst_n(rst_n), .bus(if_m), .timeout(tout_m), .st_dbg(st_m));
   jtframe_sdram_arb #(.SLOTS(SLOTS), .FIXED(1), .TOUT(8)) u_f (
      .clk(clk), .rst_n(rst_n), .bus(if_f), .timeout(tout_f), .st_dbg(st_f));

   int total = 0;
   int bad   = 0;
   // grant: {slot_we, rnw, addr, wrdata}; response: {slot_we, dout}
   logic [58:0] exp_gnt_q[$];
   logic [35:0] exp_rsp_q[$];
   logic        req_q = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] oh(input int s);
      return 4'(1 << s);
   endfunction

   task automatic set_slot(input int s, input logic rnw, input logic [21:0] addr,
                           input logic [31:0] wd);
      if_m.slot_rnw[s]           = rnw;
      if_m.slot_addr[22*s +: 22]   = addr;
      if_m.slot_wrdata[32*s +: 32] = wd;
   endtask

   task automatic push_gnt(input int s, input logic rnw, input logic [21:0] addr,
                           input logic [31:0] wd);
      exp_gnt_q.push_back({oh(s), rnw, addr, wd});
   endtask

   task automatic push_rsp(input int s, input logic [31:0] d);
      exp_rsp_q.push_back({oh(s), d});
   endtask

   // Controller model: wait for a request, ack after ack_after cycles, then
   // rdy after rdy_after cycles (0 = same cycle as ack). Returns in DONE.
   task automatic serve(input int ack_after, input int rdy_after, input logic [31:0] d);
      int n = 0;
      while (!if_m.sdram_req && n < 40) begin
         tick();
         n++;
      end
      if (!if_m.sdram_req) begin
         chk("serve_req_wait", 64'd0, 64'd1);
         return;
      end
      repeat (ack_after) tick();
      if_m.sdram_ack = 1'b1;
      if_m.sdram_din = d;
      if (rdy_after == 0) if_m.sdram_rdy = 1'b1;
      tick();
      if_m.sdram_ack = 1'b0;
      if_m.sdram_rdy = 1'b0;
      if (rdy_after > 0) begin
         repeat (rdy_after - 1) tick();
         if_m.sdram_rdy = 1'b1;
         tick();
         if_m.sdram_rdy = 1'b0;
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_slot_we"}, 64'(if_m.slot_we), 64'd0);
      chk({tag, "_din_ok"}, 64'(if_m.din_ok), 64'd0);
      chk({tag, "_dout"}, 64'(if_m.dout), 64'd0);
      chk({tag, "_sdram_req"}, 64'(if_m.sdram_req), 64'd0);
      chk({tag, "_sdram_rnw"}, 64'(if_m.sdram_rnw), 64'd1);
      chk({tag, "_sdram_addr"}, 64'(if_m.sdram_addr), 64'd0);
      chk({tag, "_sdram_wrdata"}, 64'(if_m.sdram_wrdata), 64'd0);
      chk({tag, "_timeout"}, 64'(tout_m), 64'd0);
      chk({tag, "_state"}, 64'(st_m), 64'd0);
   endtask

   // Monitor: pops the grant queue on each rising sdram_req and the response
   // queue on each din_ok of the round-robin instance.
   always @(negedge clk) begin
      if (!rst_n) begin
         req_q = 1'b0;
      end else begin
         chk("we_onehot", 64'($countones(if_m.slot_we) <= 1), 64'd1);
         if (if_m.sdram_req && !req_q) begin
            if (exp_gnt_q.size() == 0) chk("grant_unexpected", 64'(if_m.slot_we), 64'd0);
            else chk("grant", {5'd0, if_m.slot_we, if_m.sdram_rnw, if_m.sdram_addr,
                                if_m.sdram_wrdata}, {5'd0, exp_gnt_q.pop_front()});
         end
         if (if_m.din_ok) begin
            if (exp_rsp_q.size() == 0) chk("din_ok_unexpected", 64'(if_m.din_ok), 64'd0);
            else chk("response", {28'd0, if_m.slot_we, if_m.dout}, {28'd0, exp_rsp_q.pop_front()});
         end
         req_q = if_m.sdram_req;
      end
   end

   initial begin
      int n;
      int rr_order[6];
      rr_order = '{0, 2, 3, 0, 2, 3};
      if_m.slot_req = '0; if_m.slot_rnw = '1; if_m.slot_addr = '0; if_m.slot_wrdata = '0;
      if_m.sdram_ack = 1'b0; if_m.sdram_rdy = 1'b0; if_m.sdram_din = '0;
      if_f.slot_req = '0; if_f.slot_rnw = '1; if_f.slot_addr = '0; if_f.slot_wrdata = '0;
      if_f.sdram_ack = 1'b0; if_f.sdram_rdy = 1'b0; if_f.sdram_din = '0;

      // Reset values
      repeat (2) tick();
      chk_rst("reset");
      chk("reset_fixed_state", 64'(st_f), 64'd0);
      rst_n = 1'b1;
      tick();

      // Round-robin, slots 0,2,3 held high: 0,2,3,0,2,3
      for (int s = 0; s < SLOTS; s++) set_slot(s, 1'b1, 22'(22'h100 + s), 32'd0);
      for (int k = 0; k < 6; k++) begin
         push_gnt(rr_order[k], 1'b1, 22'(22'h100 + rr_order[k]), 32'd0);
         push_rsp(rr_order[k], 32'hA000_0000 + 32'(k));
      end
      if_m.slot_req = 4'b1101;
      for (int k = 0; k < 6; k++) serve(k % 3, 1 + (k % 2), 32'hA000_0000 + 32'(k));
      if_m.slot_req = '0;
      tick();

      // Fixed priority, same requesters: 0,0,0
      if_f.slot_req = 4'b1101;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!if_f.sdram_req && n < 20) begin
            tick();
            n++;
         end
         chk("fixed_grant", 64'(if_f.slot_we), 64'b0001);
         if_f.sdram_ack = 1'b1;
         if_f.sdram_rdy = 1'b1;
         tick();
         if_f.sdram_ack = 1'b0;
         if_f.sdram_rdy = 1'b0;
         chk("fixed_din_ok", 64'(if_f.din_ok), 64'd1);
         if (k == 2) if_f.slot_req = '0;
      end
      repeat (2) tick();

      // Single read, slot 1 addr 0x00123: ack cycle 3, rdy cycle 6
      set_slot(1, 1'b1, 22'h00123, 32'd0);
      push_gnt(1, 1'b1, 22'h00123, 32'd0);
      push_rsp(1, 32'hDEAD_BEEF);
      if_m.slot_req = 4'b0010;                                   // cycle 0
      tick(); if_m.slot_req = '0;                                // cycle 1
      chk("rd_req_c1", 64'(if_m.sdram_req), 64'd1);
      chk("rd_we_c1", 64'(if_m.slot_we), 64'b0010);
      tick(); chk("rd_req_c2", 64'(if_m.sdram_req), 64'd1);      // cycle 2
      tick(); chk("rd_req_c3", 64'(if_m.sdram_req), 64'd1);      // cycle 3
      if_m.sdram_ack = 1'b1;
      tick(); if_m.sdram_ack = 1'b0;                             // cycle 4
      chk("rd_req_c4", 64'(if_m.sdram_req), 64'd0);
      chk("rd_we_c4", 64'(if_m.slot_we), 64'b0010);
      tick();                                                    // cycle 5
      tick(); if_m.sdram_rdy = 1'b1; if_m.sdram_din = 32'hDEAD_BEEF;  // cycle 6
      chk("rd_din_ok_c6", 64'(if_m.din_ok), 64'd0);
      tick(); if_m.sdram_rdy = 1'b0;                             // cycle 7
      chk("rd_din_ok_c7", 64'(if_m.din_ok), 64'd1);
      chk("rd_dout_c7", 64'(if_m.dout), 64'hDEAD_BEEF);
      chk("rd_we_c7", 64'(if_m.slot_we), 64'b0010);
      tick();                                                    // cycle 8
      chk("rd_din_ok_c8", 64'(if_m.din_ok), 64'd0);
      chk("rd_we_c8", 64'(if_m.slot_we), 64'd0);

      // Write, slot 3 addr 0x3FFFFF data 0x0000A55A; dout must keep 0xDEADBEEF
      set_slot(3, 1'b0, 22'h3FFFFF, 32'h0000_A55A);
      push_gnt(3, 1'b0, 22'h3FFFFF, 32'h0000_A55A);
      push_rsp(3, 32'hDEAD_BEEF);
      if_m.slot_req = 4'b1000;
      tick(); if_m.slot_req = '0;
      for (int k = 0; k < 3; k++) begin
         chk("wr_rnw", 64'(if_m.sdram_rnw), 64'd0);
         chk("wr_addr", 64'(if_m.sdram_addr), 64'h3FFFFF);
         chk("wr_wrdata", 64'(if_m.sdram_wrdata), 64'h0000_A55A);
         if (k == 2) if_m.sdram_ack = 1'b1;
         tick();
      end
      if_m.sdram_ack = 1'b0;
      tick(); if_m.sdram_rdy = 1'b1; if_m.sdram_din = 32'h1234_5678;
      tick(); if_m.sdram_rdy = 1'b0;
      chk("wr_din_ok", 64'(if_m.din_ok), 64'd1);
      chk("wr_dout_kept", 64'(if_m.dout), 64'hDEAD_BEEF);
      tick();
      chk("wr_din_ok_after", 64'(if_m.din_ok), 64'd0);

      // ack and rdy in the same cycle, slot 2; slot 0 queued behind it
      set_slot(2, 1'b1, 22'h2AAAA, 32'd0);
      push_gnt(2, 1'b1, 22'h2AAAA, 32'd0);
      push_rsp(2, 32'h5555_AAAA);
      if_m.slot_req = 4'b0100;
      tick();                                                    // REQ
      chk("same_state_req", 64'(st_m), 64'd1);
      if_m.sdram_ack = 1'b1; if_m.sdram_rdy = 1'b1; if_m.sdram_din = 32'h5555_AAAA;
      set_slot(0, 1'b1, 22'h000ABC, 32'd0);
      push_gnt(0, 1'b1, 22'h000ABC, 32'd0);
      if_m.slot_req = 4'b0001;
      tick(); if_m.sdram_ack = 1'b0; if_m.sdram_rdy = 1'b0;      // DONE, no WAIT
      chk("same_state_done", 64'(st_m), 64'd3);
      chk("same_din_ok", 64'(if_m.din_ok), 64'd1);
      tick();
      chk("same_idle_req", 64'(if_m.sdram_req), 64'd0);
      tick();                                                    // 2 cycles after din_ok
      chk("same_next_req", 64'(if_m.sdram_req), 64'd1);
      chk("same_next_we", 64'(if_m.slot_we), 64'b0001);

      // Timeout on slot 0: rdy never comes; slot 1 waits and is granted next
      if_m.sdram_ack = 1'b1;
      set_slot(1, 1'b1, 22'h00155, 32'd0);
      push_gnt(1, 1'b1, 22'h00155, 32'd0);
      if_m.slot_req = 4'b0010;
      tick(); if_m.sdram_ack = 1'b0;
      n = 0;
      while (st_m == 2'd2 && n < 40) begin
         n++;
         tick();
      end
      chk("tout_wait_cycles", 64'(n), 64'd8);
      chk("tout_flag", 64'(tout_m), 64'd1);
      chk("tout_we", 64'(if_m.slot_we), 64'd0);
      chk("tout_state", 64'(st_m), 64'd0);
      tick();
      chk("tout_next_grant", 64'(if_m.slot_we), 64'b0010);

      // Reset in the middle of WAIT, then a late rdy that must be ignored
      if_m.sdram_ack = 1'b1;
      tick(); if_m.sdram_ack = 1'b0;
      tick();
      chk("wait_before_rst", 64'(st_m), 64'd2);
      chk("tout_sticky", 64'(tout_m), 64'd1);
      rst_n = 1'b0;
      if_m.slot_req = '0;
      #1;
      chk_rst("rst_in_wait");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick(); if_m.sdram_rdy = 1'b1; if_m.sdram_din = 32'hBAD0_0BAD;
      tick(); if_m.sdram_rdy = 1'b0;
      chk("late_rdy_state", 64'(st_m), 64'd0);
      chk("late_rdy_din_ok", 64'(if_m.din_ok), 64'd0);
      chk("late_rdy_dout", 64'(if_m.dout), 64'd0);
      repeat (2) tick();

      chk("gnt_q_empty", 64'(exp_gnt_q.size()), 64'd0);
      chk("rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
